// File: rtl/gpio_pkg.sv
// gpio_pkg: register offsets and bus constants shared by the GPIO bank and its bench.
package gpio_pkg;

    localparam int         IO_DATA_W    = 32;
    localparam int         REG_STRIDE   = 8;

    localparam logic [2:0] REG_OUT      = 3'd0;
    localparam logic [2:0] REG_DIR      = 3'd1;
    localparam logic [2:0] REG_IN       = 3'd2;
    localparam logic [2:0] REG_IRQ_EN   = 3'd3;
    localparam logic [2:0] REG_IRQ_EDGE = 3'd4;
    localparam logic [2:0] REG_IRQ_PEND = 3'd5;
    localparam logic [2:0] REG_OUT_SET  = 3'd6;
    localparam logic [2:0] REG_OUT_CLR  = 3'd7;

endpackage

// File: rtl/gpio_sync_edge.sv
// gpio_sync_edge: per-bank input synchroniser with a prev flop and rise/fall strobes.
module gpio_sync_edge #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_pin,
    output logic [WIDTH-1:0] o_in,
    output logic [WIDTH-1:0] o_rise,
    output logic [WIDTH-1:0] o_fall
);
    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [WIDTH-1:0] r_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                r_sync[s] <= '0;
            end
            r_prev <= '0;
        end else begin
            r_sync[0] <= i_pin;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_in   = r_sync[SYNC_STAGES-1];
    assign o_rise = o_in & ~r_prev;
    assign o_fall = ~o_in & r_prev;

endmodule

// File: rtl/gpio_bank.sv
// gpio_bank: BANKS x WIDTH GPIO with synchronised inputs, edge interrupts and W1C pending bits.
// Build option GPIO_ATOMIC_EN adds write-only OUT_SET / OUT_CLR at offsets 6 and 7.
module gpio_bank
    import gpio_pkg::*;
#(
    parameter int         WIDTH       = 8,
    parameter int         BANKS       = 2,
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] BASE_ADDR   = 8'h40
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             io_addr,
    input  logic                   io_en,
    input  logic                   io_we,
    input  logic [IO_DATA_W-1:0]   io_data_write,
    output logic [IO_DATA_W-1:0]   io_data_read,
    input  logic [BANKS*WIDTH-1:0] gpio_in,
    output logic [BANKS*WIDTH-1:0] gpio_out,
    output logic [BANKS*WIDTH-1:0] gpio_dir,
    output logic                   irq
);
    localparam logic [8:0] LP_WIN_END = 9'(BASE_ADDR) + 9'(BANKS * REG_STRIDE);

    logic [7:0]           w_rel;
    logic [4:0]           w_bank;
    logic [2:0]           w_off;
    logic                 w_in_win;
    logic                 w_wr;
    logic                 w_rd;
    logic [WIDTH-1:0]     w_wdata;
    logic                 w_unused;
    logic [BANKS-1:0]     w_irq_bank;
    logic [IO_DATA_W-1:0] w_bank_rd [BANKS];
    logic [IO_DATA_W-1:0] w_rd_any;
    logic [IO_DATA_W-1:0] r_rdata;
    logic                 r_irq;

    assign w_rel    = io_addr - BASE_ADDR;
    assign w_bank   = w_rel[7:3];
    assign w_off    = w_rel[2:0];
    assign w_in_win = ({1'b0, io_addr} >= {1'b0, BASE_ADDR}) && ({1'b0, io_addr} < LP_WIN_END);
    assign w_wr     = io_en & io_we & w_in_win;
    assign w_rd     = io_en & ~io_we;
    assign w_wdata  = io_data_write[WIDTH-1:0];
    // Upper write-data bits are architecturally ignored.
    assign w_unused = ^io_data_write;

    for (genvar b = 0; b < BANKS; b++) begin : g_bank
        logic [WIDTH-1:0]     r_out;
        logic [WIDTH-1:0]     r_dir;
        logic [WIDTH-1:0]     r_irq_en;
        logic [WIDTH-1:0]     r_irq_edge;
        logic [WIDTH-1:0]     r_irq_pend;
        logic [WIDTH-1:0]     w_in;
        logic [WIDTH-1:0]     w_rise;
        logic [WIDTH-1:0]     w_fall;
        logic [WIDTH-1:0]     w_edge;
        logic [WIDTH-1:0]     w_w1c;
        logic                 w_sel;
        logic                 w_bwr;
        logic [IO_DATA_W-1:0] w_rdata;

        gpio_sync_edge #(
            .WIDTH       (WIDTH),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_sync_edge (
            .clk    (clk),
            .reset  (reset),
            .i_pin  (gpio_in[b*WIDTH +: WIDTH]),
            .o_in   (w_in),
            .o_rise (w_rise),
            .o_fall (w_fall)
        );

        assign w_sel  = w_in_win && (w_bank == 5'(b));
        assign w_bwr  = w_wr && w_sel;
        assign w_edge = (w_rise & ~r_irq_edge) | (w_fall & r_irq_edge);
        assign w_w1c  = (w_bwr && (w_off == REG_IRQ_PEND)) ? w_wdata : '0;

        always_ff @(posedge clk) begin
            if (reset) begin
                r_out      <= '0;
                r_dir      <= '0;
                r_irq_en   <= '0;
                r_irq_edge <= '0;
                r_irq_pend <= '0;
            end else begin
                if (w_bwr) begin
                    case (w_off)
                        REG_OUT:      r_out      <= w_wdata;
                        REG_DIR:      r_dir      <= w_wdata;
                        REG_IRQ_EN:   r_irq_en   <= w_wdata;
                        REG_IRQ_EDGE: r_irq_edge <= w_wdata;
`ifdef GPIO_ATOMIC_EN
                        REG_OUT_SET:  r_out      <= r_out | w_wdata;
                        REG_OUT_CLR:  r_out      <= r_out & ~w_wdata;
`endif
                        default: ;
                    endcase
                end
                // A fresh edge overrides a same-cycle clear of that bit.
                r_irq_pend <= (r_irq_pend & ~w_w1c) | w_edge;
            end
        end

        always_comb begin
            w_rdata = '0;
            if (w_sel) begin
                case (w_off)
                    REG_OUT:      w_rdata = IO_DATA_W'(r_out);
                    REG_DIR:      w_rdata = IO_DATA_W'(r_dir);
                    REG_IN:       w_rdata = IO_DATA_W'(w_in);
                    REG_IRQ_EN:   w_rdata = IO_DATA_W'(r_irq_en);
                    REG_IRQ_EDGE: w_rdata = IO_DATA_W'(r_irq_edge);
                    REG_IRQ_PEND: w_rdata = IO_DATA_W'(r_irq_pend);
                    default:      w_rdata = '0;
                endcase
            end
        end

        assign w_bank_rd[b]               = w_rdata;
        assign w_irq_bank[b]              = |(r_irq_pend & r_irq_en);
        assign gpio_out[b*WIDTH +: WIDTH] = r_out;
        assign gpio_dir[b*WIDTH +: WIDTH] = r_dir;
    end

    always_comb begin
        w_rd_any = '0;
        for (int b = 0; b < BANKS; b++) begin
            w_rd_any = w_rd_any | w_bank_rd[b];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata <= '0;
            r_irq   <= 1'b0;
        end else begin
            if (w_rd) begin
                r_rdata <= w_rd_any;
            end
            r_irq <= |w_irq_bank;
        end
    end

    assign io_data_read = r_rdata;
    assign irq          = r_irq;

endmodule
